// File: rtl/ddrc_pkg.sv
// ddrc_pkg: shared register offsets, phase-stepper states and reset bit indices for the DDR control block.
package ddrc_pkg;
  localparam logic [1:0] DDRC_CTRL_RUN = 2'd0;
  localparam logic [1:0] DDRC_CTRL_PS  = 2'd1;
  localparam logic [1:0] DDRC_CTRL_RST = 2'd2;
  localparam logic [1:0] DDRC_CTRL_EN  = 2'd3;
  localparam int RST_DLY  = 0;
  localparam int RST_DCI  = 1;
  localparam int RST_MMCM = 2;
  typedef enum logic [1:0] {PS_IDLE, PS_STEP, PS_WAIT} ps_state_e;
endpackage

// File: rtl/ddrc_ps_stepper.sv
// ddrc_ps_stepper: walks the MMCM fine phase one step at a time toward the written target.
module ddrc_ps_stepper
  import ddrc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       target_we,
  input  logic [7:0] target,
  input  logic       locked,
  input  logic       ps_done,
  input  logic       clr,
  output logic       ps_en,
  output logic       ps_incdec,
  output logic [7:0] ps_out,
  output logic       ps_rdy,
  output logic       active
);
  ps_state_e  state_q, state_d;
  logic [7:0] ps_out_q, ps_out_d, target_q, target_d;
  logic       dir_q, dir_d;
  logic       up;
  assign up = target_q > ps_out_q;
  always_comb begin
    state_d  = state_q;
    ps_out_d = ps_out_q;
    target_d = target_we ? target : target_q;
    dir_d    = dir_q;
    unique case (state_q)
      PS_IDLE: state_d = (ps_out_q != target_q && locked) ? PS_STEP : PS_IDLE;
      PS_STEP: begin
        dir_d   = up;
        state_d = PS_WAIT;
      end
      PS_WAIT: if (ps_done) begin
        state_d  = PS_IDLE;
        ps_out_d = dir_q ? ((ps_out_q == 8'hff) ? ps_out_q : ps_out_q + 8'd1)
                         : ((ps_out_q == 8'h00) ? ps_out_q : ps_out_q - 8'd1);
      end
      default: state_d = PS_IDLE;
    endcase
    // an MMCM reset returns the hardware to phase 0, so any step in flight is dropped
    if (clr) begin
      state_d  = PS_IDLE;
      ps_out_d = '0;
      target_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PS_IDLE;
      ps_out_q <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ps_out_q <= ps_out_d;
      target_q <= target_d;
      dir_q    <= dir_d;
    end
  end
  assign ps_en     = state_q == PS_STEP;
  assign ps_incdec = ps_en ? up : dir_q;
  assign ps_out    = ps_out_q;
  assign ps_rdy    = state_q == PS_IDLE && ps_out_q == target_q;
  assign active    = !ps_rdy;
endmodule

// File: rtl/ddrc_control.sv
// ddrc_control: decodes AXI register writes into sequencer start, phase-shift,
// reset-pulse and enable controls for the DDR controller.
module ddrc_control
  import ddrc_pkg::*;
#(
  parameter int                          AXI_WR_ADDR_BITS  = 12,
  parameter logic [AXI_WR_ADDR_BITS-1:0] CONTROL_ADDR      = 'h000,
  parameter logic [AXI_WR_ADDR_BITS-1:0] CONTROL_ADDR_MASK = 'hffc,
  parameter int                          RST_PULSE         = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_WR_ADDR_BITS-1:0] pre_waddr,
  input  logic                        start_wburst,
  input  logic [AXI_WR_ADDR_BITS-1:0] waddr,
  input  logic                        wr_en,
  input  logic [31:0]                 wdata,
  output logic                        busy,
  input  logic                        run_busy,
  output logic [10:0]                 run_addr,
  output logic                        run_seq,
  input  logic                        locked,
  input  logic                        ps_done,
  output logic                        ps_en,
  output logic                        ps_incdec,
  output logic [7:0]                  ps_out,
  output logic                        ps_rdy,
  output logic                        dly_rst,
  output logic                        dci_rst,
  output logic                        mmcm_rst,
  output logic [7:0]                  en_bits
);
  function automatic logic sel(input logic [AXI_WR_ADDR_BITS-1:0] a);
    return ((a ^ CONTROL_ADDR) & CONTROL_ADDR_MASK) == '0;
  endfunction
  logic        we, we_run, we_ps, we_rst, we_en, active, run_pending_q;
  logic [2:0]  rst_on, rst_next;
  logic [10:0] run_addr_q;
  logic [7:0]  en_q;
  logic        unused_wdata;
  assign unused_wdata = ^wdata[31:11];
  assign we     = wr_en && sel(waddr);
  assign we_run = we && waddr[1:0] == DDRC_CTRL_RUN;
  assign we_ps  = we && waddr[1:0] == DDRC_CTRL_PS;
  assign we_rst = we && waddr[1:0] == DDRC_CTRL_RST;
  assign we_en  = we && waddr[1:0] == DDRC_CTRL_EN;
  assign busy   = start_wburst && sel(pre_waddr) && pre_waddr[1:0] == DDRC_CTRL_PS && active;
  assign run_seq = run_pending_q && !run_busy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_pending_q <= 1'b0;
      run_addr_q    <= '0;
      en_q          <= '0;
    end else begin
      run_pending_q <= we_run || (run_pending_q && run_busy);
      run_addr_q    <= we_run ? wdata[10:0] : run_addr_q;
      en_q          <= we_en ? wdata[7:0] : en_q;
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_rst
    logic [7:0] cnt_q, cnt_d;
    assign cnt_d = (we_rst && wdata[i]) ? 8'(RST_PULSE) : cnt_q - {7'd0, |cnt_q};
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
    assign rst_on[i]   = |cnt_q;
    assign rst_next[i] = |cnt_d;
  end
  // clear on the next-state value so phase drops to 0 in the same cycle mmcm_rst rises
  ddrc_ps_stepper u_ps (
    .clk       (clk),
    .rst       (rst),
    .target_we (we_ps),
    .target    (wdata[7:0]),
    .locked    (locked),
    .ps_done   (ps_done),
    .clr       (rst_next[RST_MMCM]),
    .ps_en     (ps_en),
    .ps_incdec (ps_incdec),
    .ps_out    (ps_out),
    .ps_rdy    (ps_rdy),
    .active    (active)
  );
  assign run_addr = run_addr_q;
  assign en_bits  = en_q;
  assign dly_rst  = rst_on[RST_DLY];
  assign dci_rst  = rst_on[RST_DCI];
  assign mmcm_rst = rst_on[RST_MMCM];
endmodule

// File: tb/tb_ddrc_control.sv
// tb_ddrc_control: directed vectors and multi-cycle sequences for ddrc_control.
module tb_ddrc_control;
  logic        clk = 1'b0, rst = 1'b1;
  logic [11:0] pre_waddr = '0, waddr = '0;
  logic        start_wburst = 1'b0, wr_en = 1'b0, run_busy = 1'b0, locked = 1'b1, ps_done = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, run_seq, ps_en, ps_incdec, ps_rdy, dly_rst, dci_rst, mmcm_rst;
  logic [10:0] run_addr;
  logic [7:0]  ps_out, en_bits;
  int tests = 0, fails = 0;
  int pe_cnt = 0, inc_cnt = 0, seq_cnt = 0;

  ddrc_control dut (
    .clk(clk), .rst(rst), .pre_waddr(pre_waddr), .start_wburst(start_wburst),
    .waddr(waddr), .wr_en(wr_en), .wdata(wdata), .busy(busy), .run_busy(run_busy),
    .run_addr(run_addr), .run_seq(run_seq), .locked(locked), .ps_done(ps_done),
    .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_out(ps_out), .ps_rdy(ps_rdy),
    .dly_rst(dly_rst), .dci_rst(dci_rst), .mmcm_rst(mmcm_rst), .en_bits(en_bits)
  );

  always #5 clk = ~clk;

  // MMCM model: answers each step request with ps_done four cycles later
  initial forever begin
    @(negedge clk);
    if (ps_en) begin
      pe_cnt++;
      if (ps_incdec) inc_cnt++;
      repeat (3) @(posedge clk);
      #1 ps_done = 1'b1;
      @(posedge clk);
      #1 ps_done = 1'b0;
    end
  end

  always @(negedge clk) if (run_seq) seq_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 waddr = a; wdata = d; wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_rdy(input string name);
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (ps_rdy) break;
    end
    chk(name, ps_rdy, 1);
  endtask

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    logic [7:0]  en;
    logic [10:0] ra;
    logic        seq;
  } vec_t;
  vec_t v[7];

  initial begin
    int n0, n1, n2, n3, n4;
    v[0] = '{12'h003, 32'h0000_005a, 8'h5a, 11'h000, 1'b0};
    v[1] = '{12'h000, 32'h0000_0123, 8'h5a, 11'h123, 1'b1};
    v[2] = '{12'h007, 32'h0000_00ff, 8'h5a, 11'h123, 1'b0};
    v[3] = '{12'h000, 32'hffff_f7ff, 8'h5a, 11'h7ff, 1'b1};
    v[4] = '{12'h803, 32'h0000_0011, 8'h5a, 11'h7ff, 1'b0};
    v[5] = '{12'h008, 32'h0000_0044, 8'h5a, 11'h7ff, 1'b0};
    v[6] = '{12'h003, 32'h0000_00a5, 8'ha5, 11'h7ff, 1'b0};
    cyc(3);
    rst = 1'b0;
    chk("rst_run_addr", run_addr, 0);
    chk("rst_run_seq", run_seq, 0);
    chk("rst_ps_en", ps_en, 0);
    chk("rst_ps_incdec", ps_incdec, 0);
    chk("rst_ps_out", ps_out, 0);
    chk("rst_ps_rdy", ps_rdy, 1);
    chk("rst_pulses", {dly_rst, dci_rst, mmcm_rst}, 0);
    chk("rst_en_bits", en_bits, 0);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      wr(v[i].a, v[i].d);
      chk($sformatf("vec%0d_en", i), en_bits, v[i].en);
      chk($sformatf("vec%0d_run_addr", i), run_addr, v[i].ra);
      chk($sformatf("vec%0d_run_seq", i), run_seq, v[i].seq);
      cyc(1);
      chk($sformatf("vec%0d_run_seq_clr", i), run_seq, 0);
    end

    run_busy = 1'b1;
    wr(12'h000, 32'h0ab);
    n0 = 0;
    for (int i = 0; i < 10; i++) begin
      if (run_seq) n0++;
      cyc(1);
    end
    chk("run_held_while_busy", n0, 0);
    run_busy = 1'b0;
    #1 chk("run_seq_on_busy_fall", run_seq, 1);
    chk("run_addr_busy", run_addr, 11'h0ab);
    cyc(1);
    chk("run_seq_single", run_seq, 0);
    run_busy = 1'b1;
    wr(12'h000, 32'h011);
    wr(12'h000, 32'h022);
    seq_cnt = 0;
    cyc(3);
    run_busy = 1'b0;
    cyc(5);
    chk("run_double_one_pulse", seq_cnt, 1);
    chk("run_double_addr", run_addr, 11'h022);

    pe_cnt = 0; inc_cnt = 0;
    wr(12'h001, 32'h3);
    start_wburst = 1'b1; pre_waddr = 12'h001;
    #1 chk("busy_ps_stepping", busy, 1);
    pre_waddr = 12'h000;
    #1 chk("busy_run_reg", busy, 0);
    pre_waddr = 12'h005;
    #1 chk("busy_unselected", busy, 0);
    start_wburst = 1'b0;
    wait_rdy("ps_up_rdy");
    chk("ps_up_pulses", pe_cnt, 3);
    chk("ps_up_incs", inc_cnt, 3);
    chk("ps_up_out", ps_out, 3);
    start_wburst = 1'b1; pre_waddr = 12'h001;
    #1 chk("busy_after_target", busy, 0);
    start_wburst = 1'b0;

    pe_cnt = 0; inc_cnt = 0;
    wr(12'h001, 32'h1);
    wait_rdy("ps_dn_rdy");
    chk("ps_dn_pulses", pe_cnt, 2);
    chk("ps_dn_incs", inc_cnt, 0);
    chk("ps_dn_out", ps_out, 1);

    locked = 1'b0;
    pe_cnt = 0;
    wr(12'h001, 32'h0);
    cyc(10);
    chk("unlocked_no_step", pe_cnt, 0);
    chk("unlocked_out", ps_out, 1);
    locked = 1'b1;
    wait_rdy("relock_rdy");
    chk("relock_out", ps_out, 0);

    pe_cnt = 0; inc_cnt = 0;
    wr(12'h001, 32'h5);
    n0 = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (ps_en && ps_out == 8'd1) begin
        n0 = 1;
        break;
      end
    end
    chk("retarget_reached_step", n0, 1);
    cyc(1);
    wr(12'h001, 32'h2);
    wait_rdy("retarget_rdy");
    chk("retarget_out", ps_out, 2);
    cyc(20);
    chk("retarget_pulses", pe_cnt, 2);
    chk("retarget_still_rdy", ps_rdy, 1);

    wr(12'h001, 32'h6);
    cyc(3);
    wr(12'h002, 32'h5);
    chk("mmcm_clr_out", ps_out, 0);
    n0 = 0; n1 = 0; n2 = 0; n3 = 0; n4 = 0;
    for (int i = 0; i < 12; i++) begin
      if (dly_rst) n0++;
      if (dci_rst) n1++;
      if (mmcm_rst) n2++;
      if (ps_en) n3++;
      if (ps_out != 8'd0) n4++;
      cyc(1);
    end
    chk("dly_rst_width", n0, 8);
    chk("dci_rst_width", n1, 0);
    chk("mmcm_rst_width", n2, 8);
    chk("mmcm_no_ps_en", n3, 0);
    chk("mmcm_ps_out_zero", n4, 0);
    chk("mmcm_after_rdy", ps_rdy, 1);

    run_busy = 1'b1;
    wr(12'h000, 32'h055);
    wr(12'h003, 32'hff);
    wr(12'h002, 32'h2);
    wr(12'h001, 32'h3);
    cyc(2);
    chk("pre_arst_dci", dci_rst, 1);
    chk("pre_arst_wait", {ps_en, ps_rdy}, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_run_addr", run_addr, 0);
    chk("arst_ps", {ps_en, ps_incdec, ps_rdy}, 3'b001);
    chk("arst_ps_out", ps_out, 0);
    chk("arst_pulses", {dly_rst, dci_rst, mmcm_rst}, 0);
    chk("arst_en_bits", en_bits, 0);
    cyc(2);
    rst = 1'b0;
    run_busy = 1'b0;
    pe_cnt = 0; seq_cnt = 0;
    cyc(20);
    chk("post_arst_no_ps_en", pe_cnt, 0);
    chk("post_arst_no_run", seq_cnt, 0);
    chk("post_arst_rdy", ps_rdy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ddrc_control.md
Name: ddrc_control

Overview:
- Write-side counterpart of the DDR controller status readback path.
- Decodes AXI write-channel register writes into control actions for the DDR controller:
  - sequencer start
  - MMCM phase-shift target
  - reset pulses for IDELAYCTRL, DCI and MMCM
  - static enable bits
- Contains a phase-shift stepping FSM. It walks the MMCM fine phase toward the written target one step at a time, handshaking with the MMCM. The resulting phase value is what the status readback reports.

Parameters:
- AXI_WR_ADDR_BITS, 12: width of write addresses.
- CONTROL_ADDR, 'h000: base address that selects this block.
- CONTROL_ADDR_MASK, 'hffc: address mask that selects this block.
- RST_PULSE, 8: width, in clk cycles, of each reset pulse (2..255).

Ports:
- clk  in  1  controller clock; everything is single-clock.
- rst  in  1  asynchronous, active-high reset.
- pre_waddr  in  AXI_WR_ADDR_BITS  write address valid with start_wburst.
- start_wburst  in  1  write-burst start.
- waddr  in  AXI_WR_ADDR_BITS  write address, valid with wr_en.
- wr_en  in  1  write strobe.
- wdata  in  32  write data.
- busy  out  1  combinational write-channel busy.
- run_busy  in  1  sequencer busy.
- run_addr  out  11  sequencer start address.
- run_seq  out  1  one-cycle sequencer start pulse.
- locked  in  1  MMCM and PLL locked.
- ps_done  in  1  MMCM phase-shift step complete (one-cycle pulse).
- ps_en  out  1  MMCM phase-shift step pulse.
- ps_incdec  out  1  step direction: 1 = increment, 0 = decrement.
- ps_out  out  8  current phase value.
- ps_rdy  out  1  high when the FSM is IDLE and ps_out equals the target.
- dly_rst  out  1  IDELAYCTRL reset.
- dci_rst  out  1  DCI reset.
- mmcm_rst  out  1  MMCM reset.
- en_bits  out  8  static enable register.

Behaviour:
- Select: ((waddr ^ CONTROL_ADDR) & CONTROL_ADDR_MASK) == 0. Register offset = waddr[1:0]:
  - 0 = RUN
  - 1 = PS
  - 2 = RST
  - 3 = EN
- Reset values:
  - run_addr = 0, run_seq = 0
  - ps_en = 0, ps_incdec = 0, ps_out = 0, target = 0, ps_rdy = 1
  - dly_rst = dci_rst = mmcm_rst = 0
  - en_bits = 0
  - FSM in IDLE, run_pending = 0, reset counters = 0
- busy = start_wburst && pre_waddr selects the PS register && (FSM != IDLE || ps_out != target). A new PS write is blocked until the previous target has been reached.
- RUN write:
  - Latch wdata[10:0] into run_addr and set run_pending.
  - run_seq pulses for one cycle in the first cycle where run_pending && !run_busy, and run_pending clears in the same cycle.
  - If the write and !run_busy coincide, run_seq asserts the cycle after wr_en (latency 1).
  - A second RUN write while pending overwrites run_addr; only one pulse is issued.
- PS write: target <= wdata[7:0]. The write is accepted regardless of busy; busy is advisory to the AXI side.
- PS FSM:
  - IDLE -> STEP when ps_out != target && locked && !mmcm_rst.
  - STEP, one cycle: ps_en = 1, ps_incdec = (target > ps_out). Go to WAIT.
  - WAIT: hold until ps_done, then ps_out <= ps_out ± 1 (no wrap: range 0..255, direction by unsigned compare). Go to IDLE.
  - A new target written mid-step: the current step completes, then IDLE re-evaluates. No step is ever aborted.
  - locked low during WAIT: stay in WAIT until ps_done. In IDLE no new step starts while !locked.
- RST write:
  - Bits wdata[0], [1], [2] start RST_PULSE-cycle pulses on dly_rst, dci_rst, mmcm_rst respectively.
  - Each output has its own down-counter. Rewriting a bit while its pulse is active restarts that counter.
  - The output asserts the cycle after wr_en.
  - While mmcm_rst is high: ps_out and target are forced to 0 and the FSM is forced to IDLE, because the MMCM reset restores phase 0. A step in flight is abandoned.
- EN write: en_bits <= wdata[7:0].
- Writes to unselected addresses are ignored.
- At most one register is written per cycle.
- Asynchronous rst mid-operation returns every output to its reset value immediately.

Decomposition:
- Shared package ddrc_pkg:
  - register offset constants DDRC_CTRL_RUN/PS/RST/EN
  - PS FSM state enum {IDLE, STEP, WAIT}
  - reset bit indices
- Sub-module ddrc_ps_stepper: the PS FSM with ps_out/target. Inputs: target_we, target, locked, ps_done, clr. Outputs: ps_en, ps_incdec, ps_out, ps_rdy, active.
- Reset pulse stretchers are instantiated inline, three copies.

Test Plan:
- RUN write wdata=0x123 with run_busy=0 -> run_seq one pulse 1 cycle after wr_en, run_addr=0x123. Repeat with run_busy=1 for 10 cycles -> pulse in the cycle run_busy falls.
- PS write target=3 from ps_out=0, locked=1, ps_done returned 4 cycles after each ps_en -> exactly 3 ps_en pulses with ps_incdec=1, ps_out=3, ps_rdy=1. Then target=1 -> 2 pulses with ps_incdec=0.
- busy check: start_wburst to the PS register during stepping -> busy=1. To the RUN register -> busy=0. After target reached -> busy=0.
- Target change 5->2 written while in WAIT at ps_out=1 (incrementing) -> step completes to ps_out=2, no further pulses, ps_rdy=1.
- RST write wdata=0x5 with RST_PULSE=8 -> dly_rst and mmcm_rst high exactly 8 cycles, dci_rst stays 0. During the pulse ps_out=0, target=0, no ps_en.
- Async rst asserted mid-WAIT and mid reset pulse -> all outputs at reset values within the same cycle. After release, FSM is IDLE and no ps_en occurs without a new PS write.
